// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Purpose  : Shared definitions for the RAM loader: default frame marker,
//            command codes and the byte-parser state encoding.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_GO    = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } parser_state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_parser.sv
`default_nettype none
// ============================================================================
// Module   : loader_parser
// Purpose  : Byte-stream frame parser. Decodes WRITE/GO/HALT frames, emits
//            registered single-cycle RAM write strobes and GO/HALT pulses,
//            and keeps a sticky protocol/checksum error flag.
// Ports    : clk, reset          - clock, async active-high reset
//            rx_data/rx_valid    - incoming stream byte
//            rx_ready            - byte accept (1 whenever out of reset)
//            loading             - current mode from the top level
//            wr_en/addr/data     - RAM write request, cycle after acceptance
//            go, halt            - combinational pulses on command acceptance
//            err                 - sticky error
// Revision : 1.0 - initial release
// ============================================================================
module loader_parser
  import loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter logic [23:0] VEC_BASE  = 24'hFFFFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        loading,
  output logic        wr_en,
  output logic [23:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        go,
  output logic        halt,
  output logic        err
);

  parser_state_t state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic          err_q, err_d;
  logic          frame_wr_ok_q, frame_wr_ok_d;  // WRITE frame opened in load mode
  logic          wr_en_q, wr_en_d;
  logic [23:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          rx_ready_q;
  logic          accept;
  logic [15:0]   len_full;

  assign accept   = rx_valid & rx_ready_q;
  assign len_full = {rx_data, len_lo_q};

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    addr_d        = addr_q;
    len_lo_d      = len_lo_q;
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    err_d         = err_q;
    frame_wr_ok_d = frame_wr_ok_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    go            = 1'b0;
    halt          = 1'b0;

    if (accept) begin
      unique case (state_q)
        ST_SYNC: begin
          // Anything other than the marker is line noise, not an error.
          if (rx_data == SYNC_BYTE) state_d = ST_CMD;
        end
        ST_CMD: begin
          state_d = ST_SYNC;
          unique case (rx_data)
            CMD_WRITE: begin
              state_d       = ST_ADDR;
              idx_d         = 2'd0;
              sum_d         = 8'h00;
              frame_wr_ok_d = loading;
              // A WRITE in run mode is flagged but still parsed to its end
              // so the stream stays in frame alignment.
              if (!loading) err_d = 1'b1;
            end
            CMD_GO:   go    = 1'b1;
            CMD_HALT: halt  = 1'b1;
            default:  err_d = 1'b1;
          endcase
        end
        ST_ADDR: begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0:    addr_d[7:0]   = rx_data;
            2'd1:    addr_d[15:8]  = rx_data;
            default: begin
              addr_d[23:16] = rx_data;
              idx_d         = 2'd0;
              state_d       = ST_LEN;
            end
          endcase
        end
        ST_LEN: begin
          if (idx_q == 2'd0) begin
            len_lo_d = rx_data;
            idx_d    = 2'd1;
          end else begin
            idx_d = 2'd0;
            cnt_d = len_full;
            if (len_full == 16'd0) state_d = ST_CSUM;
            else                   state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // Vector area writes are silently dropped; the address still advances.
          wr_en_d   = frame_wr_ok_q && (addr_q < VEC_BASE);
          wr_addr_d = addr_q;
          wr_data_d = rx_data;
          addr_d    = addr_q + 24'd1;
          sum_d     = sum_q + rx_data;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_data != sum_q) err_d = 1'b1;
          sum_d   = 8'h00;
          state_d = ST_SYNC;
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      idx_q         <= 2'd0;
      addr_q        <= 24'd0;
      len_lo_q      <= 8'h00;
      cnt_q         <= 16'd0;
      sum_q         <= 8'h00;
      err_q         <= 1'b0;
      frame_wr_ok_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 24'd0;
      wr_data_q     <= 8'h00;
      rx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      addr_q        <= addr_d;
      len_lo_q      <= len_lo_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      err_q         <= err_d;
      frame_wr_ok_q <= frame_wr_ok_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rx_ready_q    <= 1'b1;
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;

endmodule : loader_parser
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : ram_loader
// Purpose  : Boot/debug loader in front of the system RAM port. Holds the CPU
//            in reset while framed WRITE commands fill RAM, then hands the
//            port back to the CPU on GO; HALT re-enters load mode.
// Ports    : clk, reset                  - clock, async active-high reset
//            rx_data/rx_valid/rx_ready   - command byte stream
//            cpu_AB/cpu_DO/cpu_WE        - CPU bus request
//            cpu_RDY, cpu_reset          - CPU stall / reset control
//            ram_AB/ram_DO/ram_WE/ram_RDY- RAM port
//            loading                     - 1 = load mode
//            err                         - sticky protocol/checksum error
// Revision : 1.0 - initial release
// ============================================================================
module ram_loader
  import loader_pkg::*;
#(
  parameter bit          BOOT_LOAD = 1'b1,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter logic [23:0] VEC_BASE  = 24'hFFFFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [23:0] cpu_AB,
  input  logic [7:0]  cpu_DO,
  input  logic        cpu_WE,
  output logic        cpu_RDY,
  output logic        cpu_reset,
  output logic [23:0] ram_AB,
  output logic [7:0]  ram_DO,
  output logic        ram_WE,
  output logic        ram_RDY,
  output logic        loading,
  output logic        err
);

  logic        w_wr_en;
  logic [23:0] w_wr_addr;
  logic [7:0]  w_wr_data;
  logic        w_go;
  logic        w_halt;
  logic        loading_q, loading_d;

  loader_parser #(
    .SYNC_BYTE (SYNC_BYTE),
    .VEC_BASE  (VEC_BASE)
  ) u_parser (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .loading  (loading_q),
    .wr_en    (w_wr_en),
    .wr_addr  (w_wr_addr),
    .wr_data  (w_wr_data),
    .go       (w_go),
    .halt     (w_halt),
    .err      (err)
  );

  // The mode flag flips on the edge that accepts the command byte, so the
  // mux select changes in the same cycle the CPU is released.
  always_comb begin
    loading_d = loading_q;
    if (w_go)        loading_d = 1'b0;
    else if (w_halt) loading_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) loading_q <= BOOT_LOAD;
    else       loading_q <= loading_d;
  end

  // Purely combinational mux: the CPU sees RAM with no added latency.
  always_comb begin
    ram_RDY = 1'b1;
    if (loading_q) begin
      ram_AB    = w_wr_addr;
      ram_DO    = w_wr_data;
      ram_WE    = w_wr_en;
      cpu_RDY   = 1'b0;
      cpu_reset = 1'b1;
    end else begin
      ram_AB    = cpu_AB;
      ram_DO    = cpu_DO;
      ram_WE    = cpu_WE;
      cpu_RDY   = 1'b1;
      cpu_reset = 1'b0;
    end
  end

  assign loading = loading_q;

endmodule : ram_loader
`default_nettype wire
